ising_run_ctrl: RTL and testbench

ISING_RUN_CTRL -- requirements
Module: ising_run_ctrl

---
 rtl/ising_pkg.sv | 19 +
 rtl/spin_phase_sampler.sv | 56 +++++
 rtl/ising_run_ctrl.sv | 156 +++++++++++++++
 tb/tb_ising_run_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ising_pkg.sv
// Shared definitions for the Ising run controller: FSM state encoding and
// the width helper for the per-spin phase-match counters.
package ising_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Bits needed to count from 0 up to sample_cycles inclusive.
  function automatic int sample_cnt_w(input int sample_cycles);
    return (sample_cycles < 1) ? 1 : $clog2(sample_cycles + 1);
  endfunction

endpackage

// File: rtl/spin_phase_sampler.sv
// One spin's phase tap: a 2-flop synchroniser for the asynchronous
// oscillator phase, plus a counter of sample cycles in which the
// synchronised phase agrees with the reference (spin 0) phase.
module spin_phase_sampler
  import ising_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 255,
  parameter int CW            = sample_cnt_w(SAMPLE_CYCLES)
) (
  input  logic          clk,
  input  logic          axi_rstn,
  input  logic          phase_async,
  input  logic          ref_sync,
  input  logic          clear,
  input  logic          enable,
  output logic          phase_sync,
  output logic [CW-1:0] match_cnt
);

  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state for the synchroniser chain and the bounded match counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    sync1_d = phase_async;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (phase_sync == ref_sync) && (cnt_q < CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge axi_rstn) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!axi_rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase_sync = sync2_q;
  assign match_cnt  = cnt_q;

endmodule

// File: rtl/ising_run_ctrl.sv
// Run controller for a coupled-oscillator Ising array: gates weight writes,
// holds the oscillators in reset, lets them free-run, then majority-votes
// each spin's phase against spin 0 over a sampling window.
module ising_run_ctrl
  import ising_pkg::*;
#(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 255,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             axi_rstn,
  input  logic             start,
  input  logic [15:0]      rst_cycles,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             wr_req,
  output logic             wr_gnt,
  input  logic [N-1:0]     spin_phase,
  output logic             ising_rstn,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     spin_out
);

  localparam int               SAMP_W     = sample_cnt_w(SAMPLE_CYCLES);
  localparam logic [CNT_W-1:0] SAMPLE_LEN = CNT_W'(SAMPLE_CYCLES);
  localparam logic [SAMP_W:0]  MAJ_LIMIT  = (SAMP_W + 1)'(SAMPLE_CYCLES);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CNT_W-1:0]             run_len_q, run_len_d;
  logic                         ising_rstn_q, ising_rstn_d;
  logic                         wr_gnt_q, wr_gnt_d;
  logic                         done_q, done_d;
  logic [N-1:0]                 spin_out_q, spin_out_d;

  logic [CNT_W-1:0]             rst_len;
  logic [CNT_W-1:0]             run_len_eff;
  logic                         cnt_last;
  logic                         start_ok;
  logic                         sample_en;
  logic [N-1:0]                 sync_bits;
  logic [N-1:0][SAMP_W-1:0]     match_cnt;
  logic [N-1:0]                 majority;

  // Zero lengths are promoted to one cycle; captured only at the start edge.
  assign rst_len     = (rst_cycles == '0) ? CNT_W'(1) : CNT_W'(rst_cycles);
  assign run_len_eff = (run_cycles == '0) ? CNT_W'(1) : run_cycles;
  assign cnt_last    = (cnt_q <= CNT_W'(1));
  assign start_ok    = (state_q == ST_IDLE) && start;
  assign sample_en   = (state_q == ST_SAMPLE);

  // Per-spin synchroniser and match counter; spin 0 is the phase reference.
  for (genvar i = 0; i < N; i++) begin : g_spin
    spin_phase_sampler #(
      .SAMPLE_CYCLES(SAMPLE_CYCLES)
    ) u_sampler (
      .clk        (clk),
      .axi_rstn   (axi_rstn),
      .phase_async(spin_phase[i]),
      .ref_sync   (sync_bits[0]),
      .clear      (start_ok),
      .enable     (sample_en),
      .phase_sync (sync_bits[i]),
      .match_cnt  (match_cnt[i])
    );
  end

  // Strict-majority vote per spin; a tie does not count as in phase.
  always_comb begin
    majority    = '0;
    majority[0] = 1'b1;
    for (int i = 1; i < N; i++) begin
      majority[i] = ({match_cnt[i], 1'b0} > MAJ_LIMIT);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // FSM next-state logic; start has priority over wr_req in IDLE only.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start)       state_d = ST_HOLD;
        else if (wr_req) state_d = ST_WRITE;
      end
      ST_WRITE:  if (!wr_req)  state_d = ST_IDLE;
      ST_HOLD:   if (cnt_last) state_d = ST_RUN;
      ST_RUN:    if (cnt_last) state_d = ST_SAMPLE;
      ST_SAMPLE: if (cnt_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Phase-length down-counter: reloads at each phase boundary, never wraps.
  always_comb begin
    cnt_d     = cnt_q;
    run_len_d = run_len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d     = rst_len;
          run_len_d = run_len_eff;
        end
      end
      ST_HOLD:   cnt_d = cnt_last ? run_len_q  : cnt_q - 1'b1;
      ST_RUN:    cnt_d = cnt_last ? SAMPLE_LEN : cnt_q - 1'b1;
      ST_SAMPLE: cnt_d = cnt_last ? '0         : cnt_q - 1'b1;
      ST_DONE:   cnt_d = '0;
      default:   cnt_d = cnt_q;
    endcase
  end

  // FSM outputs: registered array controls and the result capture.
  always_comb begin
    ising_rstn_d = ising_rstn_q;
    wr_gnt_d     = (state_d == ST_WRITE);
    done_d       = (state_q == ST_DONE);
    spin_out_d   = spin_out_q;
    if (state_d == ST_HOLD)     ising_rstn_d = 1'b0;
    else if (state_d == ST_RUN) ising_rstn_d = 1'b1;
    if (state_q == ST_DONE)     spin_out_d = majority;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cnt_q        <= '0;
      run_len_q    <= '0;
      ising_rstn_q <= 1'b0;
      wr_gnt_q     <= 1'b0;
      done_q       <= 1'b0;
      spin_out_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      run_len_q    <= run_len_d;
      ising_rstn_q <= ising_rstn_d;
      wr_gnt_q     <= wr_gnt_d;
      done_q       <= done_d;
      spin_out_q   <= spin_out_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign wr_gnt     = wr_gnt_q;
  assign ising_rstn = ising_rstn_q;
  assign done       = done_q;
  assign spin_out   = spin_out_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl: a default build (SAMPLE_CYCLES=255)
// and a short even build (SAMPLE_CYCLES=8) for the tie case.
module tb_ising_run_ctrl;

  localparam int N     = 8;
  localparam int S     = 255;
  localparam int SE    = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             axi_rstn = 1'b0;
  logic             start = 1'b0;
  logic             start_e = 1'b0;
  logic             wr_req = 1'b0;
  logic             wr_req_e = 1'b0;
  logic [15:0]      rst_cycles = '0;
  logic [CNT_W-1:0] run_cycles = '0;
  logic [N-1:0]     spin_phase = '0;
  logic [N-1:0]     spin_phase_e = '0;

  logic             wr_gnt, ising_rstn, busy, done;
  logic [N-1:0]     spin_out;
  logic             wr_gnt_e, ising_rstn_e, busy_e, done_e;
  logic [N-1:0]     spin_out_e;

  int               n_cmp = 0;
  int               n_bad = 0;

  logic             tog = 1'b0;
  logic             toggle_mode = 1'b0;
  logic [N-1:0]     static_phase = 8'hF0;

  ising_run_ctrl #(.N(N), .SAMPLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .start(start), .rst_cycles(rst_cycles),
    .run_cycles(run_cycles), .wr_req(wr_req), .wr_gnt(wr_gnt),
    .spin_phase(spin_phase), .ising_rstn(ising_rstn), .busy(busy),
    .done(done), .spin_out(spin_out)
  );

  ising_run_ctrl #(.N(N), .SAMPLE_CYCLES(SE), .CNT_W(CNT_W)) dut_even (
    .clk(clk), .axi_rstn(axi_rstn), .start(start_e), .rst_cycles(rst_cycles),
    .run_cycles(run_cycles), .wr_req(wr_req_e), .wr_gnt(wr_gnt_e),
    .spin_phase(spin_phase_e), .ising_rstn(ising_rstn_e), .busy(busy_e),
    .done(done_e), .spin_out(spin_out_e)
  );

  always #5 clk = ~clk;

  // Phase taps change on the falling edge. Toggle pattern: bits 0,1,3,6
  // follow spin 0, bits 2,4,5,7 oppose it. Even build: bit1 alternates
  // against a constant spin 0 (exact tie), bit2 equal, bit3 opposite.
  always @(negedge clk) begin
    tog          = ~tog;
    spin_phase   = toggle_mode ? (tog ? 8'h4B : 8'hB4) : static_phase;
    spin_phase_e = {4'b0000, 1'b1, 1'b0, tog, 1'b0};
  end

  // Issue one start and count cycles from the start edge to the done pulse.
  task automatic run_measure(input bit sel, input bit with_wr, input bit drop_start,
                             output int lat, output int low_cyc, output int gnt_seen);
    lat = -1; low_cyc = 0; gnt_seen = 0;
    @(negedge clk);
    if (sel) start_e = 1'b1; else start = 1'b1;
    if (with_wr) wr_req = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_e = 1'b0;
    if (!(sel ? ising_rstn_e : ising_rstn)) low_cyc++;
    if (sel ? wr_gnt_e : wr_gnt) gnt_seen++;
    for (int k = 1; k <= 2000; k++) begin
      if (drop_start && k == 20) begin
        if (sel) start_e = 1'b1; else start = 1'b1;
      end else begin
        start = 1'b0; start_e = 1'b0;
      end
      @(posedge clk); #1;
      if (sel ? done_e : done) begin
        lat = k;
        break;
      end
      if (!(sel ? ising_rstn_e : ising_rstn)) low_cyc++;
      if (sel ? wr_gnt_e : wr_gnt) gnt_seen++;
    end
    start = 1'b0; start_e = 1'b0; wr_req = 1'b0;
    n_cmp++;
    if (lat < 0) begin
      n_bad++;
      $display("FAIL run_timeout: done not seen, got %0d required pulse within 2000 cycles", lat);
    end
  endtask

  task automatic test_reset();
    axi_rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b required 0", done); end
    n_cmp++; if (ising_rstn !== 1'b0) begin n_bad++; $display("FAIL reset_ising_rstn: got %b required 0", ising_rstn); end
    n_cmp++; if (wr_gnt !== 1'b0)     begin n_bad++; $display("FAIL reset_wr_gnt: got %b required 0", wr_gnt); end
    n_cmp++; if (spin_out !== 8'h00)  begin n_bad++; $display("FAIL reset_spin_out: got %h required 00", spin_out); end
    n_cmp++; if (busy_e !== 1'b0)     begin n_bad++; $display("FAIL reset_busy_even: got %b required 0", busy_e); end
    @(negedge clk);
    axi_rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    @(negedge clk);
    wr_req = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (wr_gnt !== 1'b1) begin n_bad++; $display("FAIL write_gnt_on: got %b required 1", wr_gnt); end
    n_cmp++; if (busy !== 1'b1)   begin n_bad++; $display("FAIL write_busy: got %b required 1", busy); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (wr_gnt !== 1'b1) begin n_bad++; $display("FAIL write_start_ignored: got wr_gnt %b required 1", wr_gnt); end
    wr_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (wr_gnt !== 1'b0) begin n_bad++; $display("FAIL write_gnt_off: got %b required 0", wr_gnt); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL write_back_idle: got busy %b required 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL write_start_not_queued: got busy %b required 0", busy); end
  endtask

  task automatic test_latency_static();
    int lat, low, gnt;
    rst_cycles = 16'd4; run_cycles = 32'd10;
    toggle_mode = 1'b0; static_phase = 8'hF0;
    repeat (3) @(negedge clk);
    run_measure(1'b0, 1'b0, 1'b0, lat, low, gnt);
    n_cmp++; if (lat != 270)          begin n_bad++; $display("FAIL static_latency: got %0d required 270", lat); end
    n_cmp++; if (low != 4)            begin n_bad++; $display("FAIL static_rstn_low: got %0d required 4", low); end
    n_cmp++; if (spin_out !== 8'h0F)  begin n_bad++; $display("FAIL static_spin_out: got %h required 0f", spin_out); end
    n_cmp++; if (ising_rstn !== 1'b1) begin n_bad++; $display("FAIL static_rstn_after: got %b required 1", ising_rstn); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL static_done_pulse: got %b required 0", done); end
    n_cmp++; if (spin_out !== 8'h0F)  begin n_bad++; $display("FAIL static_spin_hold: got %h required 0f", spin_out); end
  endtask

  task automatic test_back_to_back();
    int lat, low, gnt;
    rst_cycles = 16'd4; run_cycles = 32'd10;
    toggle_mode = 1'b1;
    repeat (3) @(negedge clk);
    run_measure(1'b0, 1'b1, 1'b1, lat, low, gnt);
    n_cmp++; if (lat != 270)         begin n_bad++; $display("FAIL wrstart_latency: got %0d required 270", lat); end
    n_cmp++; if (low != 4)           begin n_bad++; $display("FAIL wrstart_rstn_low: got %0d required 4", low); end
    n_cmp++; if (gnt != 0)           begin n_bad++; $display("FAIL wrstart_gnt_cycles: got %0d required 0", gnt); end
    n_cmp++; if (spin_out !== 8'h4B) begin n_bad++; $display("FAIL toggle_spin_out: got %h required 4b", spin_out); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL dropped_start_queued: got busy %b required 0", busy); end
    n_cmp++; if (wr_gnt !== 1'b0)    begin n_bad++; $display("FAIL wrstart_gnt_after: got %b required 0", wr_gnt); end
  endtask

  task automatic test_min_lengths();
    int lat, low, gnt;
    rst_cycles = 16'd0; run_cycles = 32'd0;
    toggle_mode = 1'b0; static_phase = 8'h3C;
    repeat (3) @(negedge clk);
    run_measure(1'b0, 1'b0, 1'b0, lat, low, gnt);
    n_cmp++; if (lat != S + 3)       begin n_bad++; $display("FAIL min_latency: got %0d required %0d", lat, S + 3); end
    n_cmp++; if (low != 1)           begin n_bad++; $display("FAIL min_rstn_low: got %0d required 1", low); end
    n_cmp++; if (spin_out !== 8'hC3) begin n_bad++; $display("FAIL min_spin_out: got %h required c3", spin_out); end
  endtask

  task automatic test_tie();
    int lat, low, gnt;
    rst_cycles = 16'd2; run_cycles = 32'd3;
    repeat (3) @(negedge clk);
    run_measure(1'b1, 1'b0, 1'b0, lat, low, gnt);
    n_cmp++; if (lat != 14)            begin n_bad++; $display("FAIL tie_latency: got %0d required 14", lat); end
    n_cmp++; if (low != 2)             begin n_bad++; $display("FAIL tie_rstn_low: got %0d required 2", low); end
    n_cmp++; if (spin_out_e !== 8'hF5) begin n_bad++; $display("FAIL tie_spin_out: got %h required f5", spin_out_e); end
  endtask

  task automatic test_abort();
    int pulses;
    pulses = 0;
    rst_cycles = 16'd4; run_cycles = 32'd100;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    axi_rstn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL abort_busy: got %b required 0", busy); end
    n_cmp++; if (ising_rstn !== 1'b0) begin n_bad++; $display("FAIL abort_ising_rstn: got %b required 0", ising_rstn); end
    n_cmp++; if (spin_out !== 8'h00)  begin n_bad++; $display("FAIL abort_spin_out: got %h required 00", spin_out); end
    @(negedge clk);
    axi_rstn = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_cmp++; if (pulses != 0)   begin n_bad++; $display("FAIL abort_done_pulses: got %0d required 0", pulses); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: got busy %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_latency_static();
    test_back_to_back();
    test_min_lengths();
    test_tie();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
